// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the program counter, issues one instruction-memory request at a time
// over a valid/ready handshake, presents the returned instruction until the
// core commits it, then steps to PC+4 or to the controller-selected target.
// A misaligned next PC parks the stage in a sticky fault until reset.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   PCSrc, PCTarget       redirect select / target, sampled on commit only
//   Advance               core commits the presented instruction
//   imem_req_valid/ready  fetch request handshake, imem_addr = PC
//   imem_rsp_valid/data   fetch response, accepted only while waiting
//   Instr, PC, PCPlus4    presented instruction, its address, address + 4
//   InstrValid            Instr/PC valid and awaiting commit
//   Fault                 sticky misaligned-target fault
//   RetireCount           committed instruction count (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        Advance,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic        Fault,
    output logic [31:0] RetireCount
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        FAULT = 3'd4
    } state_e;

    state_e            state_q,       state_d;
    logic [XLEN-1:0]   pc_q,          pc_d;
    logic [XLEN-1:0]   pc_plus4_q,    pc_plus4_d;
    logic [XLEN-1:0]   instr_q,       instr_d;
    logic [XLEN-1:0]   retire_q,      retire_d;
    logic              fault_q,       fault_d;
    logic              req_valid_q,   req_valid_d;
    logic              instr_valid_q, instr_valid_d;
    logic [XLEN-1:0]   next_pc;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + PC_STEP;
            instr_q       <= NOP_INSTR;
            retire_q      <= '0;
            fault_q       <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_q       <= instr_d;
            retire_q      <= retire_d;
            fault_q       <= fault_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        fault_d  = fault_q;
        next_pc  = PCSrc ? PCTarget : pc_q + PC_STEP;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (Advance) begin
                    // The instruction retires even when its successor faults
                    retire_d = retire_q + 32'd1;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a flop
        req_valid_d   = (state_d == REQ);
        instr_valid_d = (state_d == VALID);
        pc_plus4_d    = pc_d + PC_STEP;
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign Instr          = instr_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_plus4_q;
    assign InstrValid     = instr_valid_q;
    assign Fault          = fault_q;
    assign RetireCount    = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit.
// A transaction-level model (PC, retire count, presented instruction, fault)
// predicts every observed value; fetch latency is implied by stepping exactly
// the cycle count the handshake delays dictate.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, RESET_PC = 0
    logic        reset_n;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        Advance;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic        Fault;
    logic [31:0] RetireCount;

    // Wrap-around DUT, RESET_PC = FFFF_FFFC
    logic        w_reset_n;
    logic        w_pcsrc;
    logic [31:0] w_pctarget;
    logic        w_advance;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pcplus4;
    logic        w_instr_valid;
    logic        w_fault;
    logic [31:0] w_retire;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset_n(reset_n), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .Advance(Advance), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .InstrValid(InstrValid),
        .Fault(Fault), .RetireCount(RetireCount)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset_n(w_reset_n), .PCSrc(w_pcsrc), .PCTarget(w_pctarget),
        .Advance(w_advance), .imem_req_valid(w_req_valid),
        .imem_req_ready(w_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .Instr(w_instr), .PC(w_pc), .PCPlus4(w_pcplus4), .InstrValid(w_instr_valid),
        .Fault(w_fault), .RetireCount(w_retire)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_retire;
    logic [31:0] m_instr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_aligned();
        logic [31:0] r;
        r = $urandom;
        r[1:0] = 2'b00;
        return r;
    endfunction

    task automatic model_reset();
        m_pc     = 32'h0;
        m_retire = 32'h0;
        m_instr  = 32'h0000_0013;
    endtask

    task automatic check_reset_state();
        check("rst_req_valid",   32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(InstrValid),     32'd0);
        check("rst_fault",       32'(Fault),          32'd0);
        check("rst_retire",      RetireCount,         32'd0);
        check("rst_pc",          PC,                  32'd0);
        check("rst_pcplus4",     PCPlus4,             32'd4);
        check("rst_instr",       Instr,               32'h0000_0013);
    endtask

    // Entered in a REQ cycle; stalls k cycles on ready and d cycles on response
    task automatic do_fetch(input int k, input int d, input logic [31:0] data);
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr",  imem_addr,           m_pc);
        for (int i = 0; i < k; i++) begin
            imem_req_ready = 1'b0;
            Advance        = 1'($urandom_range(0, 1));
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            tick();
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr",  imem_addr,           m_pc);
        end
        imem_req_ready = 1'b1;
        Advance        = 1'($urandom_range(0, 1));
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rsp_data  = $urandom;
        tick();
        imem_req_ready = 1'b0;
        check("wait_req_valid",   32'(imem_req_valid), 32'd0);
        check("wait_instr_valid", 32'(InstrValid),     32'd0);
        for (int i = 0; i < d; i++) begin
            imem_rsp_valid = 1'b0;
            Advance        = 1'($urandom_range(0, 1));
            tick();
            check("wait_hold_instr_valid", 32'(InstrValid), 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        Advance        = 1'($urandom_range(0, 1));
        tick();
        imem_rsp_valid = 1'b0;
        Advance        = 1'b0;
        m_instr        = data;
        check("valid_instr_valid", 32'(InstrValid), 32'd1);
        check("valid_instr",       Instr,           m_instr);
        check("valid_pc",          PC,              m_pc);
        check("valid_pcplus4",     PCPlus4,         m_pc + 32'd4);
        check("valid_retire",      RetireCount,     m_retire);
        check("valid_fault",       32'(Fault),      32'd0);
    endtask

    // Entered in a VALID cycle; holds for 'hold' cycles then commits
    task automatic do_commit(input int hold, input logic src, input logic [31:0] tgt);
        logic [31:0] nxt;
        for (int i = 0; i < hold; i++) begin
            Advance        = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~m_instr;
            tick();
            check("hold_instr_valid", 32'(InstrValid), 32'd1);
            check("hold_instr",       Instr,           m_instr);
        end
        imem_rsp_valid = 1'b0;
        Advance  = 1'b1;
        PCSrc    = src;
        PCTarget = tgt;
        tick();
        Advance  = 1'b0;
        PCSrc    = 1'($urandom_range(0, 1));
        PCTarget = $urandom;
        nxt      = src ? tgt : m_pc + 32'd4;
        m_retire = m_retire + 32'd1;
        check("commit_retire",      RetireCount,     m_retire);
        check("commit_instr_valid", 32'(InstrValid), 32'd0);
        if (nxt[1:0] != 2'b00) begin
            check("fault_set",       32'(Fault),          32'd1);
            check("fault_pc",        PC,                  m_pc);
            check("fault_req_valid", 32'(imem_req_valid), 32'd0);
        end else begin
            m_pc = nxt;
            check("next_req_valid", 32'(imem_req_valid), 32'd1);
            check("next_addr",      imem_addr,           m_pc);
            check("next_fault",     32'(Fault),          32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0; PCSrc = 1'b0; PCTarget = '0; Advance = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        w_reset_n = 1'b0; w_pcsrc = 1'b0; w_pctarget = '0; w_advance = 1'b0;
        w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'hCAFE_0001;

        // Wrap-around: sequential commit from FFFF_FFFC lands on 0
        tick(); tick();
        check("w_rst_pc",      w_pc,             32'hFFFF_FFFC);
        check("w_rst_pcplus4", w_pcplus4,        32'h0);
        check("w_rst_req",     32'(w_req_valid), 32'd0);
        w_reset_n = 1'b1; w_req_ready = 1'b1; w_rsp_valid = 1'b1; w_advance = 1'b1;
        tick();
        check("w_req_valid", 32'(w_req_valid), 32'd1);
        check("w_req_addr",  w_addr,           32'hFFFF_FFFC);
        tick();
        check("w_wait_req", 32'(w_req_valid), 32'd0);
        tick();
        check("w_valid", 32'(w_instr_valid), 32'd1);
        check("w_instr", w_instr,            32'hCAFE_0001);
        tick();
        check("w_next_addr",    w_addr,           32'h0);
        check("w_next_req",     32'(w_req_valid), 32'd1);
        check("w_next_pcplus4", w_pcplus4,        32'd4);
        check("w_next_retire",  w_retire,         32'd1);
        w_reset_n = 1'b0;

        // Reset state and first request one cycle after release
        model_reset();
        check_reset_state();
        reset_n = 1'b1;
        tick();

        // Sequential fetch, zero wait states: 0, 4, 8
        for (int i = 0; i < 3; i++) begin
            do_fetch(0, 0, $urandom);
            do_commit(0, 1'b0, 32'h40);
        end
        check("retire_after_three", RetireCount, 32'd3);

        // Branches: 0xC -> 0x10, not-taken -> 0x14, back to 0x10, taken -> 0x40
        do_fetch(0, 0, $urandom); do_commit(0, 1'b0, 32'h0);
        do_fetch(0, 0, $urandom); do_commit(0, 1'b0, 32'h40);
        check("not_taken_addr", imem_addr, 32'h14);
        do_fetch(0, 0, $urandom); do_commit(1, 1'b1, 32'h10);
        do_fetch(0, 0, $urandom); do_commit(0, 1'b1, 32'h40);
        check("taken_addr", imem_addr, 32'h40);

        // Backpressure: 3 cycles not ready, 2 cycles response delay
        do_fetch(3, 2, 32'hDEAD_BEEF);
        do_commit(2, 1'b0, 32'h0);

        // Randomized transactions
        for (int i = 0; i < 25; i++) begin
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            do_commit($urandom_range(0, 2), 1'($urandom_range(0, 1)), rand_aligned());
        end

        // Reset in the middle of WAIT
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("midwait_req", 32'(imem_req_valid), 32'd0);
        reset_n = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        model_reset();
        check_reset_state();
        reset_n = 1'b1;
        tick();

        // Misaligned target: sticky fault, only reset clears it
        do_fetch(1, 1, $urandom);
        do_commit(0, 1'b1, 32'h22);
        for (int i = 0; i < 4; i++) begin
            Advance = 1'b1; PCSrc = 1'b1; PCTarget = rand_aligned();
            imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
            tick();
            check("fault_sticky",      32'(Fault),          32'd1);
            check("fault_no_req",      32'(imem_req_valid), 32'd0);
            check("fault_instr_valid", 32'(InstrValid),     32'd0);
            check("fault_pc_hold",     PC,                  m_pc);
            check("fault_retire_hold", RetireCount,         m_retire);
        end
        Advance = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        model_reset();
        check_reset_state();
        reset_n = 1'b1;
        tick();
        check("post_fault_req",  32'(imem_req_valid), 32'd1);
        check("post_fault_addr", imem_addr,           32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
